// File: rtl/sgdmac_wb_responder.sv
// -----------------------------------------------------------------------------
// sgdmac_wb_responder
//
// Wishbone slave responder that sits behind one SGDMAC master bus (A or B).
// It is a word-addressed RAM inside a decoded byte window. It answers classic
// and incrementing-burst cycles, and it can add programmable wait states,
// retry injection and end-of-data marking so the DMA engine can be tested
// against a bus that does not always cooperate.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   addr            byte address of the current beat (the master supplies
//                   an address for every beat)
//   wdat, sel, we   write data, byte enables, 1 = write
//   rdat            read data, valid while ack = 1
//   cyc, stb, lock  Wishbone cycle, strobe, locked cycle (lock blocks retry)
//   cti             000 classic, 010 incrementing burst, 111 end of burst
//   ack/err/retry   registered one-cycle responses, mutually exclusive
//   eod             end-of-data flag, only ever raised together with ack
//   cfg_wait        wait states before the first ack of a cycle or burst
//   cfg_retry_per   retry on every Nth new request (0 = never)
//   cfg_eod_cnt     eod on every Nth acked beat (0 = never)
//   beat_cnt        acked beats since reset, wraps at 2^16
// -----------------------------------------------------------------------------
module sgdmac_wb_responder #(
   parameter int                DWIDTH    = 32,
   parameter int                AWIDTH    = 32,
   parameter int                MEM_DEPTH = 1024,
   parameter logic [AWIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [AWIDTH-1:0]   addr,
   input  logic [DWIDTH-1:0]   wdat,
   output logic [DWIDTH-1:0]   rdat,
   input  logic [DWIDTH/8-1:0] sel,
   input  logic                we,
   input  logic                cyc,
   input  logic                stb,
   input  logic                lock,
   input  logic [2:0]          cti,
   output logic                ack,
   output logic                err,
   output logic                retry,
   output logic                eod,
   input  logic [3:0]          cfg_wait,
   input  logic [7:0]          cfg_retry_per,
   input  logic [15:0]         cfg_eod_cnt,
   output logic [15:0]         beat_cnt
);

   localparam int SEL_W    = DWIDTH / 8;
   localparam int LANE_LOG = $clog2(SEL_W);
   localparam int IDX_W    = $clog2(MEM_DEPTH);
   localparam int WIN_LOG  = IDX_W + LANE_LOG;

   // Only the incrementing-burst code continues a burst. Both 000 and 111 end
   // the transfer after the current beat.
   localparam logic [2:0] CTI_INCR = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_BURST,
      ST_RESP
   } state_t;

   // ---------------------------------------------------------------------------
   // Address decode. BASE_ADDR is aligned to the window size, so a hit is a
   // compare of the bits above the window. The word index is the window offset
   // without the byte-lane bits.
   // ---------------------------------------------------------------------------
   logic             hit;
   logic [IDX_W-1:0] idx;
   logic             unused_lane_bits;

   assign hit              = (addr[AWIDTH-1:WIN_LOG] == BASE_ADDR[AWIDTH-1:WIN_LOG]);
   assign idx              = addr[WIN_LOG-1:LANE_LOG];
   assign unused_lane_bits = ^addr[LANE_LOG-1:0];

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t             state_q,     state_d;
   logic [3:0]         wait_cnt_q,  wait_cnt_d;
   logic [7:0]         retry_cnt_q, retry_cnt_d;
   logic [15:0]        eod_cnt_q,   eod_cnt_d;
   logic [15:0]        beat_cnt_q,  beat_cnt_d;
   logic               ack_q,       ack_d;
   logic               err_q,       err_d;
   logic               retry_q,     retry_d;
   logic               eod_q,       eod_d;
   logic [DWIDTH-1:0]  rdat_q,      rdat_d;

   logic [7:0]         retry_inc;
   logic [15:0]        eod_inc;
   logic               do_beat;     // the current beat is acked on this edge
   logic               mem_we;

   logic [DWIDTH-1:0]  mem [MEM_DEPTH];

   assign retry_inc = retry_cnt_q + 8'd1;
   assign eod_inc   = eod_cnt_q + 16'd1;

   // ---------------------------------------------------------------------------
   // Next state and responses
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned below gets a default first. If any path
      // left one of them unassigned, that signal would become a latch.
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      retry_cnt_d = retry_cnt_q;
      err_d       = 1'b0;
      retry_d     = 1'b0;
      do_beat     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cyc && stb) begin
               // Every new request advances the retry counter. The counter
               // wraps when it reaches the period, whether or not a retry is
               // actually issued (a miss or a locked cycle still wraps it).
               // With a period of 0 the counter stays at 0.
               retry_cnt_d = (retry_inc >= cfg_retry_per) ? 8'd0 : retry_inc;
               if (!hit) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if ((cfg_retry_per != 8'd0) && (retry_inc == cfg_retry_per)
                            && !lock) begin
                  retry_d = 1'b1;
                  state_d = ST_RESP;
               end else if (cfg_wait == 4'd0) begin
                  do_beat = 1'b1;
                  state_d = (cti == CTI_INCR) ? ST_BURST : ST_RESP;
               end else begin
                  // This cycle already counts as the first wait state.
                  wait_cnt_d = cfg_wait - 4'd1;
                  state_d    = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            if (!cyc) begin
               state_d = ST_IDLE;
            end else if (wait_cnt_q != 4'd0) begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end else if (!hit) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               do_beat = 1'b1;
               state_d = (cti == CTI_INCR) ? ST_BURST : ST_RESP;
            end
         end

         ST_BURST: begin
            // After the first beat there are no more wait states. A beat is
            // acked on every cycle that stb is high. While stb is low the
            // responder waits in this state.
            if (!cyc) begin
               state_d = ST_IDLE;
            end else if (stb) begin
               if (!hit) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  do_beat = 1'b1;
                  if (cti != CTI_INCR) state_d = ST_RESP;
               end
            end
         end

         ST_RESP: begin
            // Dead cycle with all responses low. It gives every classic beat
            // at least two cycles and gives the master time to drop stb.
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      ack_d = do_beat;
   end

   // ---------------------------------------------------------------------------
   // Per-beat side effects: beat count, eod marking, read data, write enable
   // ---------------------------------------------------------------------------
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      eod_cnt_d  = eod_cnt_q;
      eod_d      = 1'b0;
      rdat_d     = rdat_q;
      mem_we     = 1'b0;

      if (do_beat) begin
         beat_cnt_d = beat_cnt_q + 16'd1;
         // The eod counter clears when it reaches the period. If the period
         // is lowered below the current count, it also clears on the next
         // beat instead of running until it wraps.
         eod_cnt_d  = (eod_inc >= cfg_eod_cnt) ? 16'd0 : eod_inc;
         eod_d      = (cfg_eod_cnt != 16'd0) && (eod_inc == cfg_eod_cnt);
         if (we) begin
            // A write in the same cycle as reset must not change memory.
            mem_we = !rst;
         end else begin
            rdat_d = mem[idx];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments. All flops then
      // sample their inputs at the same edge, whatever order the blocks run.
      if (rst) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 4'd0;
         retry_cnt_q <= 8'd0;
         eod_cnt_q   <= 16'd0;
         beat_cnt_q  <= 16'd0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         retry_q     <= 1'b0;
         eod_q       <= 1'b0;
         rdat_q      <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         eod_cnt_q   <= eod_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         retry_q     <= retry_d;
         eod_q       <= eod_d;
         rdat_q      <= rdat_d;
      end
   end

   // NOTE: the storage array has no reset. Clearing a RAM takes one cycle per
   // word, and a reset term would stop the array from mapping onto RAM macros.
   // Software must write a word before it reads that word.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < SEL_W; i++) begin
            if (sel[i]) mem[idx][i*8 +: 8] <= wdat[i*8 +: 8];
         end
      end
   end

   assign ack      = ack_q;
   assign err      = err_q;
   assign retry    = retry_q;
   assign eod      = eod_q;
   assign rdat     = rdat_q;
   assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_sgdmac_wb_responder.sv
// -----------------------------------------------------------------------------
// tb_sgdmac_wb_responder
//
// Directed bench for sgdmac_wb_responder. The stimulus tasks push the response
// they expect into a scoreboard queue: the kind, the cycle it should appear
// on, the read data and the eod flag. A separate monitor pops one entry for
// every response the DUT raises and compares the two. Counter and reset values
// are checked directly from the stimulus thread.
// -----------------------------------------------------------------------------
module tb_sgdmac_wb_responder;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam logic [2:0]  K_ACK = 3'b100;
   localparam logic [2:0]  K_ERR = 3'b010;
   localparam logic [2:0]  K_RTY = 3'b001;
   localparam logic [2:0]  CTI_CLASSIC = 3'b000;
   localparam logic [2:0]  CTI_INCR    = 3'b010;
   localparam logic [2:0]  CTI_EOB     = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdat = '0;
   logic [31:0] rdat;
   logic [3:0]  sel = '0;
   logic        we = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        lock = 1'b0;
   logic [2:0]  cti = CTI_CLASSIC;
   logic        ack, err, retry, eod;
   logic [3:0]  cfg_wait = '0;
   logic [7:0]  cfg_retry_per = '0;
   logic [15:0] cfg_eod_cnt = '0;
   logic [15:0] beat_cnt;

   sgdmac_wb_responder #(
      .DWIDTH   (32),
      .AWIDTH   (32),
      .MEM_DEPTH(1024),
      .BASE_ADDR(BASE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .addr         (addr),
      .wdat         (wdat),
      .rdat         (rdat),
      .sel          (sel),
      .we           (we),
      .cyc          (cyc),
      .stb          (stb),
      .lock         (lock),
      .cti          (cti),
      .ack          (ack),
      .err          (err),
      .retry        (retry),
      .eod          (eod),
      .cfg_wait     (cfg_wait),
      .cfg_retry_per(cfg_retry_per),
      .cfg_eod_cnt  (cfg_eod_cnt),
      .beat_cnt     (beat_cnt)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      logic [2:0]  kind;
      bit          chk_rdat;
      logic [31:0] rdat;
      logic        eod;
      int          cyc;
      int          tag;
   } exp_t;

   exp_t exp_q[$];
   int   tag_n  = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
      end
   endtask

   task automatic push(input logic [2:0] kind, input bit chk, input logic [31:0] rd,
                       input logic ev, input int at);
      exp_t e;
      e.kind = kind; e.chk_rdat = chk; e.rdat = rd; e.eod = ev; e.cyc = at; e.tag = tag_n;
      tag_n++;
      exp_q.push_back(e);
   endtask

   // Monitor: raises one comparison set for every response the DUT presents.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack || err || retry || eod) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", {61'd0, ack, err, retry}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("resp%0d_kind", e.tag), {61'd0, ack, err, retry}, {61'd0, e.kind});
               check($sformatf("resp%0d_cycle", e.tag), cyc_cnt, e.cyc);
               check($sformatf("resp%0d_eod", e.tag), eod, e.eod);
               if (e.chk_rdat) check($sformatf("resp%0d_rdat", e.tag), rdat, e.rdat);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0; cti = CTI_CLASSIC;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One classic beat. Returns on the negedge where the response is seen,
   // with cyc/stb already dropped.
   task automatic classic(input string name, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input bit lk,
                          input logic [2:0] kind, input logic [31:0] exp_rd);
      int n;
      @(negedge clk);
      push(kind, (kind == K_ACK) && !w, exp_rd, 1'b0,
           cyc_cnt + 1 + ((kind == K_ACK) ? int'(cfg_wait) : 0));
      addr = a; wdat = d; sel = s; we = w; lock = lk; cti = CTI_CLASSIC;
      cyc = 1'b1; stb = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ack || err || retry) && n < 40);
      check({name, "_responded"}, ack || err || retry, 1'b1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0;
   endtask

   // Incrementing burst of n beats. Beat i carries data seed+i at address
   // a0+4*i. If rst_beat > 0, reset is raised during the ack of that beat
   // (counted from 1).
   task automatic burst(input string name, input bit w, input logic [31:0] a0, input int n,
                        input logic [31:0] seed, input int eod_per, input int rst_beat);
      int s, k, last;
      @(negedge clk);
      s    = cyc_cnt;
      last = (rst_beat > 0) ? rst_beat : n;
      for (int i = 0; i < last; i++)
         push(K_ACK, !w, seed + i, (eod_per != 0) && (((i + 1) % eod_per) == 0),
              s + 1 + int'(cfg_wait) + i);
      addr = a0; wdat = seed; sel = 4'hF; we = w; lock = 1'b0;
      cti  = (n == 1) ? CTI_EOB : CTI_INCR;
      cyc  = 1'b1; stb = 1'b1;
      for (int i = 0; i < last; i++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!ack && k < 40);
         check($sformatf("%s_b%0d_acked", name, i), ack, 1'b1);
         if (i + 1 == rst_beat) begin
            rst = 1'b1;
            @(negedge clk);
            check({name, "_rst_ack"}, ack, 1'b0);
            check({name, "_rst_eod"}, eod, 1'b0);
            check({name, "_rst_rdat"}, rdat, 32'd0);
            check({name, "_rst_beat_cnt"}, beat_cnt, 16'd0);
            rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
            return;
         end else if (i + 1 < n) begin
            addr = a0 + 32'(4 * (i + 1));
            wdat = seed + 32'(i + 1);
            cti  = (i + 2 == n) ? CTI_EOB : CTI_INCR;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      check("rst_ack", ack, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_retry", retry, 1'b0);
      check("rst_eod", eod, 1'b0);
      check("rst_rdat", rdat, 32'd0);
      check("rst_beat_cnt", beat_cnt, 16'd0);

      // Classic write, then read back, no wait states.
      classic("wr_a5", 1, BASE + 32'h10, 32'hA5A5_A5A5, 4'hF, 0, K_ACK, 32'h0);
      classic("rd_a5", 0, BASE + 32'h10, 32'h0, 4'hF, 0, K_ACK, 32'hA5A5_A5A5);
      check("beat_cnt_after_classic", beat_cnt, 16'd2);

      // Byte-enable merge.
      classic("wr_ff", 1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, K_ACK, 32'h0);
      classic("wr_sel", 1, BASE + 32'h20, 32'h1234_5678, 4'h3, 0, K_ACK, 32'h0);
      classic("rd_sel", 0, BASE + 32'h20, 32'h0, 4'hF, 0, K_ACK, 32'hFFFF_5678);
      check("beat_cnt_after_sel", beat_cnt, 16'd5);

      // Three wait states: the first ack comes 4 cycles after stb, and the
      // remaining beats are acked back to back.
      cfg_wait = 4'd3;
      burst("bw8", 1, BASE + 32'h100, 8, 32'hC0DE_0000, 0, 0);
      check("beat_cnt_after_bw8", beat_cnt, 16'd13);
      burst("br8", 0, BASE + 32'h100, 8, 32'hC0DE_0000, 0, 0);
      check("beat_cnt_after_br8", beat_cnt, 16'd21);
      classic("rd_wait3", 0, BASE + 32'h10, 32'h0, 4'hF, 0, K_ACK, 32'hA5A5_A5A5);
      check("beat_cnt_after_wait3", beat_cnt, 16'd22);

      // Retry on every 2nd new request. A locked cycle suppresses the retry.
      do_reset();
      check("beat_cnt_after_rst2", beat_cnt, 16'd0);
      cfg_wait = 4'd0;
      cfg_retry_per = 8'd2;
      classic("rty_r1", 0, BASE + 32'h10, 32'h0, 4'hF, 0, K_ACK, 32'hA5A5_A5A5);
      classic("rty_r2", 0, BASE + 32'h10, 32'h0, 4'hF, 0, K_RTY, 32'h0);
      classic("rty_r3", 0, BASE + 32'h10, 32'h0, 4'hF, 0, K_ACK, 32'hA5A5_A5A5);
      classic("lk_r1", 0, BASE + 32'h10, 32'h0, 4'hF, 1, K_ACK, 32'hA5A5_A5A5);
      classic("lk_r2", 0, BASE + 32'h20, 32'h0, 4'hF, 1, K_ACK, 32'hFFFF_5678);
      classic("lk_r3", 0, BASE + 32'h10, 32'h0, 4'hF, 1, K_ACK, 32'hA5A5_A5A5);
      check("beat_cnt_after_retry", beat_cnt, 16'd5);
      cfg_retry_per = 8'd0;

      // Out-of-window accesses return err and leave memory untouched. The
      // address just past the window would alias word 0 if it were not decoded.
      classic("wr_w0", 1, BASE, 32'h0000_1111, 4'hF, 0, K_ACK, 32'h0);
      classic("wr_miss_hi", 1, BASE + 32'h1000, 32'hDEAD_BEEF, 4'hF, 0, K_ERR, 32'h0);
      classic("wr_miss_lo", 1, BASE - 32'h4, 32'hDEAD_BEEF, 4'hF, 0, K_ERR, 32'h0);
      classic("rd_miss_hi", 0, BASE + 32'h1000, 32'h0, 4'hF, 0, K_ERR, 32'h0);
      classic("rd_w0", 0, BASE, 32'h0, 4'hF, 0, K_ACK, 32'h0000_1111);
      check("beat_cnt_after_err", beat_cnt, 16'd7);

      // eod on every 4th beat. A second burst is cut short by reset.
      do_reset();
      cfg_eod_cnt = 16'd4;
      burst("eod10", 1, BASE + 32'h200, 10, 32'h5EED_0000, 4, 0);
      check("beat_cnt_after_eod10", beat_cnt, 16'd10);
      do_reset();
      burst("rst6", 1, BASE + 32'h300, 10, 32'h7777_0000, 4, 6);
      classic("rd_rst_b2", 0, BASE + 32'h304, 32'h0, 4'hF, 0, K_ACK, 32'h7777_0001);
      classic("rd_rst_b6", 0, BASE + 32'h314, 32'h0, 4'hF, 0, K_ACK, 32'h7777_0005);
      check("beat_cnt_final", beat_cnt, 16'd2);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
